// File: rtl/ili9341_init_seq.sv
// ILI9341 power-up sequencer: walks a fixed command/data/delay table and
// offers each byte to the SPI transmitter over a valid/ready handshake.
module ili9341_init_seq #(
  parameter int unsigned DELAY_TICKS = 16000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       tx_ready,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  output logic       tx_dc,
  output logic       init_done
);

  localparam int unsigned TW = (DELAY_TICKS > 1) ? $clog2(DELAY_TICKS) : 1;
  localparam logic [TW-1:0] TICK_LOAD = TW'(DELAY_TICKS - 1);

  localparam logic [1:0] T_CMD = 2'b00;
  localparam logic [1:0] T_DAT = 2'b01;
  localparam logic [1:0] T_DLY = 2'b10;

  typedef enum logic [2:0] {IDLE, FETCH, SEND, DELAY, DONE} state_t;

  state_t        state, state_nx;
  logic [3:0]    pc, pc_nx;
  logic [TW-1:0] tick, tick_nx;
  logic [7:0]    ms, ms_nx;
  logic          tx_valid_nx, tx_dc_nx, init_done_nx;
  logic [7:0]    tx_data_nx;
  logic [1:0]    ent_type;
  logic [7:0]    ent_val;

  // Init table; unused indices decode as the end marker
  always_comb begin
    ent_type = 2'b11;
    ent_val  = 8'h00;
    case (pc)
      4'd0: begin ent_type = T_CMD; ent_val = 8'h01; end
      4'd1: begin ent_type = T_DLY; ent_val = 8'd5;   end
      4'd2: begin ent_type = T_CMD; ent_val = 8'h11; end
      4'd3: begin ent_type = T_DLY; ent_val = 8'd120; end
      4'd4: begin ent_type = T_CMD; ent_val = 8'h3A; end
      4'd5: begin ent_type = T_DAT; ent_val = 8'h55; end
      4'd6: begin ent_type = T_CMD; ent_val = 8'h29; end
      default: begin ent_type = 2'b11; ent_val = 8'h00; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pc        <= '0;
      tick      <= '0;
      ms        <= '0;
      tx_valid  <= 1'b0;
      tx_data   <= '0;
      tx_dc     <= 1'b0;
      init_done <= 1'b0;
    end else begin
      state     <= state_nx;
      pc        <= pc_nx;
      tick      <= tick_nx;
      ms        <= ms_nx;
      tx_valid  <= tx_valid_nx;
      tx_data   <= tx_data_nx;
      tx_dc     <= tx_dc_nx;
      init_done <= init_done_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    pc_nx        = pc;
    tick_nx      = tick;
    ms_nx        = ms;
    tx_valid_nx  = tx_valid;
    tx_data_nx   = tx_data;
    tx_dc_nx     = tx_dc;
    init_done_nx = init_done;
    case (state)
      IDLE: if (start) state_nx = FETCH;
      FETCH: begin
        case (ent_type)
          T_CMD, T_DAT: begin
            pc_nx       = pc + 4'd1;
            state_nx    = SEND;
            tx_valid_nx = 1'b1;
            tx_data_nx  = ent_val;
            tx_dc_nx    = ent_type[0];
          end
          T_DLY: begin
            pc_nx = pc + 4'd1;
            if (ent_val != 8'd0) begin
              state_nx = DELAY;
              tick_nx  = TICK_LOAD;
              ms_nx    = ent_val - 8'd1;
            end
          end
          default: begin
            state_nx     = DONE;
            init_done_nx = 1'b1;
          end
        endcase
      end
      SEND: if (tx_ready) begin
        tx_valid_nx = 1'b0;
        state_nx    = FETCH;
      end
      DELAY: begin
        if (tick == '0) begin
          if (ms == 8'd0) begin
            state_nx = FETCH;
          end else begin
            ms_nx   = ms - 8'd1;
            tick_nx = TICK_LOAD;
          end
        end else begin
          tick_nx = tick - 1'b1;
        end
      end
      DONE: ;
      default: state_nx = IDLE;
    endcase
  end

endmodule
